ex_stage: RTL
=============

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline; consumes the ID/EX pipeline register outputs and feeds the EX/MEM register.
- Applies operand forwarding, ALU and shift operations, destination register select, and an iterative multiply/divide unit with HI/LO registers.
- While an earlier mult/div is still busy, any HI/LO-dependent op raises a stall to the hazard unit.

Parameters:
- MD_BITS, 1, quotient/product bits resolved per cycle (legal: 1, 2, 4); mult/div latency N = 32/MD_BITS cycles.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- RegDst, slide, ALUSrc, RegWrite  in  1 each  control from ID/EX
- Aluop  in  3  {Aluop1,Aluop2,Aluop3} from ID/EX
- RegOut1, RegOut2, Extend  in  32 each  operands and sign-extended immediate
- Rt, Rd  in  5 each  register specifiers
- Funct  in  6  R-type function
- fwd_a, fwd_b  in  2 each  00 regfile, 01 exmem_result, 10 memwb_result, 11 regfile
- exmem_result, memwb_result  in  32 each  forwarded values
- alu_result  out  32  combinational result to EX/MEM
- store_data  out  32  forwarded operand B before the ALUSrc mux
- write_reg  out  5  RegDst ? Rd : Rt
- reg_write_out  out  1  RegWrite & ~md_stall & ~ovf
- md_stall  out  1  freeze PC, IF/ID and ID/EX; bubble EX/MEM
- md_busy  out  1  mult/div in progress
- ovf  out  1  signed overflow (see Optional Feature)

Behaviour:
- Operand A = fwd_a-selected value.
- Operand B = ALUSrc ? Extend : fwd_b-selected value.
- Aluop decode:
  - 000 add
  - 001 sub
  - 010 R-type (decode Funct)
  - 011 and with zero-extended Extend[15:0]
  - 100 or with zero-extended Extend[15:0]
  - 101 slt
  - 110 lui: {Extend[15:0],16'h0}
  - 111 alu_result = 0
- R-type Funct (hex):
  - 20/21 add, 22/23 sub, 24 and, 25 or, 26 xor, 27 nor
  - 2A slt (signed), 2B sltu
  - 00 sll, 02 srl, 03 sra: shifts B by shamt = Extend[10:6] when slide=1, else by A[4:0]
  - 18 mult, 19 multu, 1A div, 1B divu
  - 10 mfhi, 12 mflo, 11 mthi (HI<=A), 13 mtlo (LO<=A)
  - unlisted Funct: result 0
- alu_result is 0 for mult/div/mthi/mtlo; reg_write_out follows RegWrite, and ID drives RegWrite=0 for these.
- md_op = Aluop==010 & Funct in {18,19,1A,1B,10,11,12,13}.
- md_stall = md_busy & md_op, combinational. While stalled the same instruction is re-presented each cycle and nothing issues.
- FSM states IDLE, RUN:
  - IDLE: mult/div in EX and not stalled → latch |A|,|B| and sign flags, counter=0, go to RUN. md_busy is high from the next cycle.
  - RUN: counter increments by 1 each cycle. At counter==N-1: sign-corrected result written to {HI,LO}, next state IDLE.
  - A mult/div issued at the end of cycle 0 makes md_busy high for cycles 1..N. HI/LO update at the end of cycle N; an mfhi in EX at cycle N+1 reads the new value.
- Arithmetic:
  - mult: 64-bit two's-complement product.
  - div: quotient truncates toward zero; remainder takes the dividend's sign. LO=quotient, HI=remainder.
  - divide by zero: LO=32'hFFFFFFFF, HI=dividend (unsigned magnitude, sign-corrected as usual).
  - 0x80000000 / -1: LO=0x80000000, HI=0.
- mthi/mtlo in IDLE write at the clock edge and are visible to the next instruction.
- Reset: state IDLE, counter 0, HI=LO=0, md_busy=0, md_stall=0. Reset during RUN aborts the operation; HI/LO are reset to 0.
- Forward priority is set externally; fwd 11 is treated as 00.

Optional Feature:
- OVERFLOW_TRAP_EN defined: signed overflow on add (Funct 20), sub (Funct 22), Aluop 000 or Aluop 001 drives ovf=1 and forces reg_write_out=0. alu_result still carries the wrapped sum.
- Undefined: ovf tied 0; all adds/subs wrap silently.

Test Plan:
- Forwarding: RegOut1=1, exmem_result=5, fwd_a=01, Funct 20, RegOut2=3 → alu_result=8. With fwd_b=10 and memwb_result=7 → 12.
- Shifts: slide=1, Extend[10:6]=4, B=0x80000000: sra → 0xF8000000, srl → 0x08000000. With slide=0 and A=36, sll by A[4:0]=4 → 0x00000000.
- mult: A=-3, B=7, MD_BITS=1 → md_busy high exactly 32 cycles. mfhi presented during busy → md_stall=1, reg_write_out=0. After release mflo=0xFFFFFFEB, mfhi=0xFFFFFFFF.
- div: A=-7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu by 0 with A=9 → LO=0xFFFFFFFF, HI=9.
- Reset: assert rst at cycle 10 of a running divu → next cycle md_busy=0, HI=LO=0. A following mult starts cleanly.
- OVERFLOW_TRAP_EN: add 0x7FFFFFFF+1 → ovf=1, reg_write_out=0. With the macro undefined → result 0x80000000, reg_write_out=1.

Source files
------------

// File: rtl/ex_stage_if.sv
// ID/EX-to-EX/MEM bus of the MIPS execute stage: control, operands, forwarding and results.
interface ex_stage_if;
  logic        RegDst;
  logic        slide;
  logic        ALUSrc;
  logic        RegWrite;
  logic [2:0]  Aluop;
  logic [31:0] RegOut1;
  logic [31:0] RegOut2;
  logic [31:0] Extend;
  logic [4:0]  Rt;
  logic [4:0]  Rd;
  logic [5:0]  Funct;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [31:0] exmem_result;
  logic [31:0] memwb_result;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  write_reg;
  logic        reg_write_out;
  logic        md_stall;
  logic        md_busy;
  logic        ovf;

  modport master (
    output RegDst, slide, ALUSrc, RegWrite, Aluop, RegOut1, RegOut2, Extend,
           Rt, Rd, Funct, fwd_a, fwd_b, exmem_result, memwb_result,
    input  alu_result, store_data, write_reg, reg_write_out, md_stall, md_busy, ovf
  );

  modport slave (
    input  RegDst, slide, ALUSrc, RegWrite, Aluop, RegOut1, RegOut2, Extend,
           Rt, Rd, Funct, fwd_a, fwd_b, exmem_result, memwb_result,
    output alu_result, store_data, write_reg, reg_write_out, md_stall, md_busy, ovf
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding, ALU/shifter, iterative mult/div with HI/LO and stall.
// Optional macro OVERFLOW_TRAP_EN enables signed-overflow detection on add/sub (ovf output).
module ex_stage #(
  parameter int MD_BITS = 1
) (
  input logic     clk,
  input logic     rst,
  ex_stage_if.slave bus
);
  localparam int         N    = 32 / MD_BITS;
  localparam logic [4:0] LAST = 5'(N - 1);

  typedef enum logic {IDLE, RUN} md_state_t;

  md_state_t   state_reg;
  logic [4:0]  count_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic [63:0] prod_reg;
  logic [31:0] shift_reg;
  logic [31:0] rem_reg;
  logic [31:0] opnd_reg;
  logic        is_div_reg;
  logic        neg_q_reg;
  logic        neg_r_reg;
  logic        div_zero_reg;

  logic [31:0] op_a;
  logic [31:0] fwd_b_val;
  logic [31:0] op_b;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic        is_rtype;
  logic        md_op;
  logic        is_muldiv;
  logic        md_issue;
  logic        signed_op;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        ovf_int;

  always_comb begin
    case (bus.fwd_a)
      2'b01:   op_a = bus.exmem_result;
      2'b10:   op_a = bus.memwb_result;
      default: op_a = bus.RegOut1;
    endcase
    case (bus.fwd_b)
      2'b01:   fwd_b_val = bus.exmem_result;
      2'b10:   fwd_b_val = bus.memwb_result;
      default: fwd_b_val = bus.RegOut2;
    endcase
  end

  assign op_b  = bus.ALUSrc ? bus.Extend : fwd_b_val;
  assign sum   = op_a + op_b;
  assign diff  = op_a - op_b;
  assign shamt = bus.slide ? bus.Extend[10:6] : op_a[4:0];

  assign is_rtype  = (bus.Aluop == 3'b010);
  assign is_muldiv = is_rtype && (bus.Funct inside {6'h18, 6'h19, 6'h1A, 6'h1B});
  assign md_op     = is_rtype && (bus.Funct inside {6'h18, 6'h19, 6'h1A, 6'h1B,
                                                    6'h10, 6'h11, 6'h12, 6'h13});
  assign bus.md_busy  = (state_reg == RUN);
  assign bus.md_stall = bus.md_busy & md_op;
  assign md_issue     = is_muldiv && (state_reg == IDLE);

  // Odd Funct codes (multu/divu) are the unsigned variants.
  assign signed_op = ~bus.Funct[0];
  assign sign_a    = signed_op & op_a[31];
  assign sign_b    = signed_op & op_b[31];
  assign mag_a     = sign_a ? (32'd0 - op_a) : op_a;
  assign mag_b     = sign_b ? (32'd0 - op_b) : op_b;

  always_comb begin
    result = 32'd0;
    case (bus.Aluop)
      3'b000: result = sum;
      3'b001: result = diff;
      3'b010: begin
        case (bus.Funct)
          6'h20, 6'h21: result = sum;
          6'h22, 6'h23: result = diff;
          6'h24:        result = op_a & op_b;
          6'h25:        result = op_a | op_b;
          6'h26:        result = op_a ^ op_b;
          6'h27:        result = ~(op_a | op_b);
          6'h2A:        result = {31'd0, $signed(op_a) < $signed(op_b)};
          6'h2B:        result = {31'd0, op_a < op_b};
          6'h00:        result = op_b << shamt;
          6'h02:        result = op_b >> shamt;
          6'h03:        result = $signed(op_b) >>> shamt;
          6'h10:        result = hi_reg;
          6'h12:        result = lo_reg;
          default:      result = 32'd0;
        endcase
      end
      3'b011:  result = op_a & {16'h0000, bus.Extend[15:0]};
      3'b100:  result = op_a | {16'h0000, bus.Extend[15:0]};
      3'b101:  result = {31'd0, $signed(op_a) < $signed(op_b)};
      3'b110:  result = {bus.Extend[15:0], 16'h0000};
      default: result = 32'd0;
    endcase
  end

`ifdef OVERFLOW_TRAP_EN
  logic add_chk;
  logic sub_chk;
  always_comb begin
    add_chk = (bus.Aluop == 3'b000) || (is_rtype && bus.Funct == 6'h20);
    sub_chk = (bus.Aluop == 3'b001) || (is_rtype && bus.Funct == 6'h22);
  end
  assign ovf_int = (add_chk && (op_a[31] == op_b[31]) && (sum[31]  != op_a[31])) ||
                   (sub_chk && (op_a[31] != op_b[31]) && (diff[31] != op_a[31]));
`else
  assign ovf_int = 1'b0;
`endif

  assign bus.ovf           = ovf_int;
  assign bus.alu_result    = result;
  assign bus.store_data    = fwd_b_val;
  assign bus.write_reg     = bus.RegDst ? bus.Rd : bus.Rt;
  assign bus.reg_write_out = bus.RegWrite & ~bus.md_stall & ~ovf_int;

  // Unrolled per-cycle datapath: MD_BITS shift-add (mult, MSB first) or restoring-divide steps.
  logic [63:0] p_st [0:MD_BITS];
  logic [31:0] s_st [0:MD_BITS];
  logic [31:0] r_st [0:MD_BITS];

  assign p_st[0] = prod_reg;
  assign s_st[0] = shift_reg;
  assign r_st[0] = rem_reg;

  generate
    for (genvar gi = 0; gi < MD_BITS; gi++) begin : g_step
      logic [32:0] trial;
      logic        ge;
      assign trial = {r_st[gi], s_st[gi][31]} - {1'b0, opnd_reg};
      assign ge    = ~trial[32];
      assign p_st[gi+1] = {p_st[gi][62:0], 1'b0} +
                          (s_st[gi][31] ? {32'd0, opnd_reg} : 64'd0);
      assign s_st[gi+1] = {s_st[gi][30:0], is_div_reg & ge};
      assign r_st[gi+1] = ge ? trial[31:0] : {r_st[gi][30:0], s_st[gi][31]};
    end
  endgenerate

  logic [63:0] prod_final;
  logic [31:0] quo_final;
  logic [31:0] rem_final;

  assign prod_final = neg_q_reg ? (64'd0 - p_st[MD_BITS]) : p_st[MD_BITS];
  assign quo_final  = div_zero_reg ? 32'hFFFF_FFFF :
                      (neg_q_reg ? (32'd0 - s_st[MD_BITS]) : s_st[MD_BITS]);
  assign rem_final  = neg_r_reg ? (32'd0 - r_st[MD_BITS]) : r_st[MD_BITS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      count_reg    <= 5'd0;
      hi_reg       <= 32'd0;
      lo_reg       <= 32'd0;
      prod_reg     <= 64'd0;
      shift_reg    <= 32'd0;
      rem_reg      <= 32'd0;
      opnd_reg     <= 32'd0;
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (md_issue) begin
            state_reg    <= RUN;
            count_reg    <= 5'd0;
            prod_reg     <= 64'd0;
            rem_reg      <= 32'd0;
            shift_reg    <= mag_a;
            opnd_reg     <= mag_b;
            is_div_reg   <= bus.Funct[1];
            neg_q_reg    <= sign_a ^ sign_b;
            neg_r_reg    <= sign_a;
            div_zero_reg <= (op_b == 32'd0);
          end else if (is_rtype && bus.Funct == 6'h11) begin
            hi_reg <= op_a;
          end else if (is_rtype && bus.Funct == 6'h13) begin
            lo_reg <= op_a;
          end
        end
        RUN: begin
          prod_reg  <= p_st[MD_BITS];
          shift_reg <= s_st[MD_BITS];
          rem_reg   <= r_st[MD_BITS];
          count_reg <= count_reg + 5'd1;
          if (count_reg == LAST) begin
            state_reg <= IDLE;
            count_reg <= 5'd0;
            if (is_div_reg) begin
              hi_reg <= rem_final;
              lo_reg <= quo_final;
            end else begin
              hi_reg <= prod_final[63:32];
              lo_reg <= prod_final[31:0];
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule
